alu_rs: RTL and testbench

- Reservation station directly upstream of the combinational `alu` in the dynamic-pipeline execute path.
- Buffers dispatched ALU ops whose operands may still be pending, and captures operands from the common data bus (CDB).
- Selects the oldest op with both operands ready and presents `aluc`/`src1`/`src2` plus the destination tag to the ALU through a registered valid/ready issue port.

---
 rtl/alu_rs_pkg.sv | 39 +++
 rtl/alu_rs_select.sv | 24 ++
 rtl/alu_rs.sv | 183 ++++++++++++++++++
 tb/tb_alu_rs.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station.
// ALUC encodings mirror the downstream ALU decode.
package alu_rs_pkg;

    localparam int ALU_RS_TAG_W  = 4;
    localparam int ALU_RS_DATA_W = 32;
    localparam int ALUC_W        = 4;

    localparam logic [ALUC_W-1:0] ALUC_ADDU = 4'b0000;
    localparam logic [ALUC_W-1:0] ALUC_SUBU = 4'b0001;
    localparam logic [ALUC_W-1:0] ALUC_ADD  = 4'b0010;
    localparam logic [ALUC_W-1:0] ALUC_SUB  = 4'b0011;
    localparam logic [ALUC_W-1:0] ALUC_AND  = 4'b0100;
    localparam logic [ALUC_W-1:0] ALUC_OR   = 4'b0101;
    localparam logic [ALUC_W-1:0] ALUC_XOR  = 4'b0110;
    localparam logic [ALUC_W-1:0] ALUC_NOR  = 4'b0111;
    // LUI and SLL ignore the opcode LSB in the ALU (100x / 111x)
    localparam logic [ALUC_W-1:0] ALUC_LUI  = 4'b1000;
    localparam logic [ALUC_W-1:0] ALUC_SLTU = 4'b1010;
    localparam logic [ALUC_W-1:0] ALUC_SLT  = 4'b1011;
    localparam logic [ALUC_W-1:0] ALUC_SRA  = 4'b1100;
    localparam logic [ALUC_W-1:0] ALUC_SRL  = 4'b1101;
    localparam logic [ALUC_W-1:0] ALUC_SLL  = 4'b1110;

    typedef struct packed {
        logic                     rdy;
        logic [ALU_RS_DATA_W-1:0] val;
        logic [ALU_RS_TAG_W-1:0]  tag;
    } rs_src_t;

    typedef struct packed {
        logic                    busy;
        logic [ALUC_W-1:0]       aluc;
        logic [ALU_RS_TAG_W-1:0] dtag;
        rs_src_t                 s1;
        rs_src_t                 s2;
    } rs_entry_t;

endpackage

// File: rtl/alu_rs_select.sv
// Oldest-eligible picker: age[j][i]=1 means entry j is older than entry i.
// Produces a one-hot grant plus a valid flag.
module alu_rs_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]        elig,
    input  logic [N-1:0][N-1:0] age,
    output logic [N-1:0]        grant,
    output logic                valid
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pick
            logic [N-1:0] older;
            for (genvar gj = 0; gj < N; gj++) begin : g_col
                assign older[gj] = age[gj][gi];
            end
            assign grant[gi] = elig[gi] & ~|(elig & older);
        end
    endgenerate

    assign valid = |elig;

endmodule

// File: rtl/alu_rs.sv
// Reservation station feeding the ALU: CDB wakeup, age-ordered select, registered issue.
// Optional performance counters are built when ALU_RS_PERF_EN is defined.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_DEPTH = 4,
    parameter int TAG_W    = ALU_RS_TAG_W,
    parameter int DATA_W   = ALU_RS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [3:0]        disp_aluc,
    input  logic [TAG_W-1:0]  disp_tag,
    input  logic              disp_s1_rdy,
    input  logic [DATA_W-1:0] disp_s1_val,
    input  logic [TAG_W-1:0]  disp_s1_tag,
    input  logic              disp_s2_rdy,
    input  logic [DATA_W-1:0] disp_s2_val,
    input  logic [TAG_W-1:0]  disp_s2_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [3:0]        iss_aluc,
    output logic [DATA_W-1:0] iss_src1,
    output logic [DATA_W-1:0] iss_src2,
    output logic [TAG_W-1:0]  iss_tag
`ifdef ALU_RS_PERF_EN
    ,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_full_cnt
`endif
);

    rs_entry_t                       entry_reg [RS_DEPTH];
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_reg;
    logic [RS_DEPTH-1:0]             busy;
    logic [RS_DEPTH-1:0]             elig;
    logic [RS_DEPTH-1:0]             grant;
    logic [RS_DEPTH-1:0]             alloc_oh;
    logic                            sel_valid;
    logic                            disp_fire;
    logic                            issue_load;
    rs_entry_t                       new_entry;
    logic [3:0]                      sel_aluc;
    logic [DATA_W-1:0]               sel_src1;
    logic [DATA_W-1:0]               sel_src2;
    logic [TAG_W-1:0]                sel_tag;

    generate
        for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_state
            assign busy[gi] = entry_reg[gi].busy;
            assign elig[gi] = entry_reg[gi].busy & entry_reg[gi].s1.rdy & entry_reg[gi].s2.rdy;
        end
    endgenerate

    alu_rs_select #(.N(RS_DEPTH)) u_select (
        .elig  (elig),
        .age   (age_reg),
        .grant (grant),
        .valid (sel_valid)
    );

    assign disp_ready = ~&busy;
    assign disp_fire  = disp_valid & disp_ready;
    assign issue_load = (~iss_valid | iss_ready) & sel_valid;

    always_comb begin
        logic found;
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!busy[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // A source still pending at dispatch can be satisfied by the broadcast of the same edge
    always_comb begin
        new_entry        = '0;
        new_entry.busy   = 1'b1;
        new_entry.aluc   = disp_aluc;
        new_entry.dtag   = disp_tag;
        new_entry.s1.tag = disp_s1_tag;
        new_entry.s2.tag = disp_s2_tag;
        new_entry.s1.rdy = disp_s1_rdy | (cdb_valid & (disp_s1_tag == cdb_tag));
        new_entry.s2.rdy = disp_s2_rdy | (cdb_valid & (disp_s2_tag == cdb_tag));
        new_entry.s1.val = disp_s1_rdy ? disp_s1_val : cdb_data;
        new_entry.s2.val = disp_s2_rdy ? disp_s2_val : cdb_data;
    end

    always_comb begin
        sel_aluc = '0;
        sel_src1 = '0;
        sel_src2 = '0;
        sel_tag  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
                sel_aluc = sel_aluc | entry_reg[i].aluc;
                sel_src1 = sel_src1 | entry_reg[i].s1.val;
                sel_src2 = sel_src2 | entry_reg[i].s2.val;
                sel_tag  = sel_tag  | entry_reg[i].dtag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_reg[i].busy <= 1'b0;
            end
            age_reg <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (cdb_valid && entry_reg[i].busy) begin
                    if (!entry_reg[i].s1.rdy && entry_reg[i].s1.tag == cdb_tag) begin
                        entry_reg[i].s1.rdy <= 1'b1;
                        entry_reg[i].s1.val <= cdb_data;
                    end
                    if (!entry_reg[i].s2.rdy && entry_reg[i].s2.tag == cdb_tag) begin
                        entry_reg[i].s2.rdy <= 1'b1;
                        entry_reg[i].s2.val <= cdb_data;
                    end
                end
                if (issue_load && grant[i]) begin
                    entry_reg[i].busy <= 1'b0;
                end
                // New entry is younger than every currently busy entry
                if (disp_fire) begin
                    if (alloc_oh[i]) begin
                        entry_reg[i] <= new_entry;
                        age_reg[i]   <= '0;
                    end else begin
                        age_reg[i] <= (age_reg[i] & ~alloc_oh) | (busy[i] ? alloc_oh : '0);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_aluc  <= '0;
            iss_src1  <= '0;
            iss_src2  <= '0;
            iss_tag   <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (issue_load) begin
            iss_valid <= 1'b1;
            iss_aluc  <= sel_aluc;
            iss_src1  <= sel_src1;
            iss_src2  <= sel_src2;
            iss_tag   <= sel_tag;
        end else if (iss_ready) begin
            iss_valid <= 1'b0;
        end
    end

`ifdef ALU_RS_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_full_cnt  <= '0;
        end else begin
            if (iss_valid && iss_ready) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (disp_valid && !disp_ready) begin
                perf_full_cnt <= perf_full_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: dispatch, wakeup, age order, stall, flush.
module tb_alu_rs;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [3:0]        disp_aluc;
    logic [TAG_W-1:0]  disp_tag;
    logic              disp_s1_rdy;
    logic [DATA_W-1:0] disp_s1_val;
    logic [TAG_W-1:0]  disp_s1_tag;
    logic              disp_s2_rdy;
    logic [DATA_W-1:0] disp_s2_val;
    logic [TAG_W-1:0]  disp_s2_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              iss_valid;
    logic              iss_ready;
    logic [3:0]        iss_aluc;
    logic [DATA_W-1:0] iss_src1;
    logic [DATA_W-1:0] iss_src2;
    logic [TAG_W-1:0]  iss_tag;
`ifdef ALU_RS_PERF_EN
    logic [31:0]       perf_issue_cnt;
    logic [31:0]       perf_full_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alu_rs dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_aluc   (disp_aluc),
        .disp_tag    (disp_tag),
        .disp_s1_rdy (disp_s1_rdy),
        .disp_s1_val (disp_s1_val),
        .disp_s1_tag (disp_s1_tag),
        .disp_s2_rdy (disp_s2_rdy),
        .disp_s2_val (disp_s2_val),
        .disp_s2_tag (disp_s2_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_aluc    (iss_aluc),
        .iss_src1    (iss_src1),
        .iss_src2    (iss_src2),
        .iss_tag     (iss_tag)
`ifdef ALU_RS_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_full_cnt  (perf_full_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [3:0] aluc, input logic [3:0] dtag,
                            input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [3:0] t2);
        disp_valid  = 1'b1;
        disp_aluc   = aluc;
        disp_tag    = dtag;
        disp_s1_rdy = r1;
        disp_s1_val = v1;
        disp_s1_tag = t1;
        disp_s2_rdy = r2;
        disp_s2_val = v2;
        disp_s2_tag = t2;
    endtask

    task automatic broadcast(input logic [3:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; iss_ready = 1'b1;
        disp_aluc = '0; disp_tag = '0; disp_s1_rdy = 1'b0; disp_s1_val = '0; disp_s1_tag = '0;
        disp_s2_rdy = 1'b0; disp_s2_val = '0; disp_s2_tag = '0; cdb_tag = '0; cdb_data = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        check("rst_iss_tag", 64'(iss_tag), 64'd0);
        check("rst_iss_src1", 64'(iss_src1), 64'd0);

        // Both-ready ADD: issue appears after the second edge
        dispatch(4'b0010, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        tick();
        disp_valid = 1'b0;
        check("add_lat1_valid", 64'(iss_valid), 64'd0);
        tick();
        check("add_valid", 64'(iss_valid), 64'd1);
        check("add_aluc", 64'(iss_aluc), 64'h2);
        check("add_src1", 64'(iss_src1), 64'd5);
        check("add_src2", 64'(iss_src2), 64'd7);
        check("add_tag", 64'(iss_tag), 64'd3);
        tick();
        check("add_drain", 64'(iss_valid), 64'd0);
        check("add_empty_ready", 64'(disp_ready), 64'd1);

        // SUB with src2 waiting on tag 6
        dispatch(4'b0011, 4'd5, 1'b1, 32'd9, 4'd0, 1'b0, 32'd0, 4'd6);
        tick();
        disp_valid = 1'b0;
        check("sub_wait0", 64'(iss_valid), 64'd0);
        tick();
        check("sub_wait1", 64'(iss_valid), 64'd0);
        broadcast(4'd6, 32'd4);
        tick();
        cdb_valid = 1'b0;
        check("sub_cdb_edge", 64'(iss_valid), 64'd0);
        tick();
        check("sub_valid", 64'(iss_valid), 64'd1);
        check("sub_aluc", 64'(iss_aluc), 64'h3);
        check("sub_src1", 64'(iss_src1), 64'd9);
        check("sub_src2", 64'(iss_src2), 64'd4);
        check("sub_tag", 64'(iss_tag), 64'd5);
        tick();
        check("sub_drain", 64'(iss_valid), 64'd0);

        // Fill station: entry k waits on tag k, destination 8+k
        for (int k = 1; k <= 4; k++) begin
            dispatch(4'b0000, 4'(8 + k), 1'b1, 32'(k * 10), 4'd0, 1'b0, 32'd0, 4'(k));
            tick();
        end
        check("full_ready", 64'(disp_ready), 64'd0);
        check("full_idle", 64'(iss_valid), 64'd0);
        dispatch(4'b0101, 4'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        broadcast(4'd4, 32'h44);
        tick();
        check("full_refuse_ready", 64'(disp_ready), 64'd0);
        check("full_w1_valid", 64'(iss_valid), 64'd0);
        broadcast(4'd2, 32'h22);
        tick();
        disp_valid = 1'b0;
        check("full_w2_tag", 64'(iss_tag), 64'd12);
        check("full_w2_src2", 64'(iss_src2), 64'h44);
        check("full_w2_src1", 64'(iss_src1), 64'd40);
        check("full_reopen", 64'(disp_ready), 64'd1);
        broadcast(4'd1, 32'h11);
        tick();
        check("full_w3_tag", 64'(iss_tag), 64'd10);
        check("full_w3_src2", 64'(iss_src2), 64'h22);
        broadcast(4'd3, 32'h33);
        tick();
        cdb_valid = 1'b0;
        check("full_w4_tag", 64'(iss_tag), 64'd9);
        check("full_w4_src2", 64'(iss_src2), 64'h11);
        tick();
        check("full_w5_tag", 64'(iss_tag), 64'd11);
        check("full_w5_src2", 64'(iss_src2), 64'h33);
        tick();
        check("full_no_ghost", 64'(iss_valid), 64'd0);

        // Stall: two ready ops with iss_ready low
        iss_ready = 1'b0;
        dispatch(4'b0100, 4'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        tick();
        dispatch(4'b0101, 4'd2, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0);
        tick();
        disp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("stall_valid", 64'(iss_valid), 64'd1);
            check("stall_tag", 64'(iss_tag), 64'd1);
            check("stall_src1", 64'(iss_src1), 64'd1);
            check("stall_aluc", 64'(iss_aluc), 64'h4);
            tick();
        end
        iss_ready = 1'b1;
        tick();
        check("stall_second_valid", 64'(iss_valid), 64'd1);
        check("stall_second_tag", 64'(iss_tag), 64'd2);
        check("stall_second_src2", 64'(iss_src2), 64'd4);
        tick();
        check("stall_drain", 64'(iss_valid), 64'd0);

        // Dispatch-time capture from a same-cycle broadcast
        dispatch(4'b0110, 4'd7, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0);
        broadcast(4'd2, 32'hDEADBEEF);
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        check("cap_lat_valid", 64'(iss_valid), 64'd0);
        tick();
        check("cap_valid", 64'(iss_valid), 64'd1);
        check("cap_src1", 64'(iss_src1), 64'hDEADBEEF);
        check("cap_tag", 64'(iss_tag), 64'd7);
        tick();
        check("cap_drain", 64'(iss_valid), 64'd0);

        // Flush with issue register full and three pending entries
        iss_ready = 1'b0;
        dispatch(4'b0000, 4'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        tick();
        dispatch(4'b0000, 4'd2, 1'b0, 32'd0, 4'd5, 1'b1, 32'd1, 4'd0);
        tick();
        dispatch(4'b0000, 4'd3, 1'b0, 32'd0, 4'd6, 1'b1, 32'd1, 4'd0);
        tick();
        dispatch(4'b0000, 4'd4, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd5);
        tick();
        disp_valid = 1'b0;
        check("pre_flush_valid", 64'(iss_valid), 64'd1);
        check("pre_flush_ready", 64'(disp_ready), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        iss_ready = 1'b1;
        check("flush_valid", 64'(iss_valid), 64'd0);
        check("flush_ready", 64'(disp_ready), 64'd1);
        broadcast(4'd5, 32'd1);
        tick();
        broadcast(4'd6, 32'd1);
        tick();
        cdb_valid = 1'b0;
        check("flush_ghost0", 64'(iss_valid), 64'd0);
        tick();
        check("flush_ghost1", 64'(iss_valid), 64'd0);
        tick();
        check("flush_ghost2", 64'(iss_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
